// File: rtl/mux_timer_sel.sv
// mux_timer_sel: registered N-source selector for the timer display path.
// Picks one timer source for the display. The source can be chosen manually
// through a request/acknowledge handshake, or the block can rotate through the
// sources on its own (auto-scan). After each source change the output is
// blanked for a short window. A hold mode freezes the displayed value.
module mux_timer_sel #(
  parameter int WIDTH     = 16,
  parameter int N_SRC     = 4,
  parameter int SEL_W     = 4,
  parameter int BLANK_CYC = 2,
  parameter int SCAN_DIV  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src,
  input  logic [1:0]             mode,
  input  logic                   sel_req,
  input  logic [SEL_W-1:0]       sel,
  output logic                   sel_ack,
  output logic                   sel_err,
  output logic [SEL_W-1:0]       cur_sel,
  output logic [WIDTH-1:0]       dout,
  output logic                   blank,
  output logic                   busy
);

  // Slots beyond N_SRC read as zero, so every select code indexes a real entry.
  localparam int N_SLOT = 1 << SEL_W;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int BCNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam bit HAS_BLANK = (BLANK_CYC > 0);

  // The blank counter is loaded with BLANK_CYC-1 and the window ends on the
  // edge where it reads zero, which gives exactly BLANK_CYC blanked cycles.
  localparam logic [BCNT_W-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BCNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEL_W:0]    N_SRC_EXT  = (SEL_W + 1)'(N_SRC);
  localparam logic [SEL_W-1:0]  LAST_SEL   = SEL_W'(N_SRC - 1);

  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BLANK  = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               sel_ack_q, sel_ack_d;
  logic               sel_err_q, sel_err_d;
  logic [BCNT_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;

  logic [WIDTH-1:0]   src_arr [N_SLOT];
  logic               sel_in_range;
  logic [SEL_W-1:0]   next_scan_sel;

  // Unpack the flat source bus into an indexable array.
  for (genvar k = 0; k < N_SLOT; k++) begin : g_src
    if (k < N_SRC) begin : g_used
      assign src_arr[k] = src[k*WIDTH +: WIDTH];
    end else begin : g_unused
      assign src_arr[k] = '0;
    end
  end

  assign sel_in_range  = ({1'b0, sel} < N_SRC_EXT);
  assign next_scan_sel = (cur_sel_q == LAST_SEL) ? '0 : cur_sel_q + 1'b1;

  // Next-state logic: handshake, auto-scan stepping, blanking and hold.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    dout_d      = dout_q;
    sel_ack_d   = 1'b0;
    sel_err_d   = 1'b0;
    blank_cnt_d = blank_cnt_q;
    scan_cnt_d  = scan_cnt_q;

    unique case (state_q)
      RUN: begin
        dout_d = src_arr[cur_sel_q];
        if (mode == MODE_HOLD) begin
          state_d = FROZEN;
        end else if (sel_req && sel_in_range) begin
          sel_ack_d  = 1'b1;
          scan_cnt_d = '0;
          if (sel != cur_sel_q) begin
            cur_sel_d = sel;
            if (HAS_BLANK) begin
              state_d     = BLANK;
              blank_cnt_d = BLANK_LOAD;
              dout_d      = '0;
            end
          end
        end else begin
          sel_err_d = sel_req;
          if (mode == MODE_AUTO) begin
            if (scan_cnt_q == SCAN_LAST) begin
              scan_cnt_d = '0;
              cur_sel_d  = next_scan_sel;
              if (HAS_BLANK) begin
                state_d     = BLANK;
                blank_cnt_d = BLANK_LOAD;
                dout_d      = '0;
              end
            end else begin
              scan_cnt_d = scan_cnt_q + 1'b1;
            end
          end else begin
            scan_cnt_d = '0;
          end
        end
      end

      BLANK: begin
        dout_d = '0;
        if (blank_cnt_q == '0) begin
          state_d = RUN;
          dout_d  = src_arr[cur_sel_q];
        end else begin
          blank_cnt_d = blank_cnt_q - 1'b1;
        end
      end

      FROZEN: begin
        if (mode != MODE_HOLD) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cur_sel_q   <= '0;
      dout_q      <= '0;
      sel_ack_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      blank_cnt_q <= '0;
      scan_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      dout_q      <= dout_d;
      sel_ack_q   <= sel_ack_d;
      sel_err_q   <= sel_err_d;
      blank_cnt_q <= blank_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
    end
  end

  assign sel_ack = sel_ack_q;
  assign sel_err = sel_err_q;
  assign cur_sel = cur_sel_q;
  assign dout    = dout_q;
  assign blank   = (state_q == BLANK);
  assign busy    = (state_q != RUN);

endmodule

// File: tb/tb_mux_timer_sel.sv
// tb_mux_timer_sel: directed bench for mux_timer_sel with a response scoreboard.
module tb_mux_timer_sel;

  localparam int WIDTH     = 16;
  localparam int N_SRC     = 4;
  localparam int SEL_W     = 4;
  localparam int BLANK_CYC = 2;
  localparam int SCAN_DIV  = 8;

  typedef struct packed {
    logic             ack;
    logic             err;
    logic [SEL_W-1:0] sel;
  } resp_t;

  logic                   clk;
  logic                   rst;
  logic [N_SRC*WIDTH-1:0] src;
  logic [1:0]             mode;
  logic                   sel_req;
  logic [SEL_W-1:0]       sel;
  logic                   sel_ack;
  logic                   sel_err;
  logic [SEL_W-1:0]       cur_sel;
  logic [WIDTH-1:0]       dout;
  logic                   blank;
  logic                   busy;

  int nChecks = 0;
  int nFails  = 0;

  resp_t            respQ [$];
  logic [SEL_W-1:0] stepQ [$];
  logic [SEL_W-1:0] prevSel;

  mux_timer_sel #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W),
    .BLANK_CYC(BLANK_CYC), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .src(src), .mode(mode),
    .sel_req(sel_req), .sel(sel), .sel_ack(sel_ack), .sel_err(sel_err),
    .cur_sel(cur_sel), .dout(dout), .blank(blank), .busy(busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [SEL_W-1:0] s, input logic [1:0] m);
    sel_req = req;
    sel     = s;
    mode    = m;
  endtask

  task automatic expectResp(input logic a, input logic e, input logic [SEL_W-1:0] s);
    resp_t r;
    r.ack = a;
    r.err = e;
    r.sel = s;
    respQ.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake pulses pop the response queue; a select change with no
  // ack is an auto-scan step and pops the step queue.
  always @(negedge clk) begin
    resp_t            r;
    logic [SEL_W-1:0] s;
    if (rst) begin
      prevSel = cur_sel;
    end else begin
      if (sel_ack || sel_err) begin
        if (respQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_response: actual ack=%0b err=%0b required no pulse", sel_ack, sel_err);
        end else begin
          r = respQ.pop_front();
          checkOutput("resp_ack", 32'(sel_ack), 32'(r.ack));
          checkOutput("resp_err", 32'(sel_err), 32'(r.err));
          checkOutput("resp_cur_sel", 32'(cur_sel), 32'(r.sel));
        end
      end else if (cur_sel != prevSel) begin
        if (stepQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_sel_change: actual=%0d required=%0d", cur_sel, prevSel);
        end else begin
          s = stepQ.pop_front();
          checkOutput("scan_step_sel", 32'(cur_sel), 32'(s));
        end
      end
      prevSel = cur_sel;
    end
  end

  initial begin
    logic [SEL_W-1:0] scanSeq [4];
    int               scanGap [4];
    logic [SEL_W-1:0] startSel;
    int               n;

    scanSeq[0] = 4'd1; scanSeq[1] = 4'd2; scanSeq[2] = 4'd3; scanSeq[3] = 4'd0;
    scanGap[0] = SCAN_DIV;
    scanGap[1] = SCAN_DIV + BLANK_CYC;
    scanGap[2] = SCAN_DIV + BLANK_CYC;
    scanGap[3] = SCAN_DIV + BLANK_CYC;

    // Reset with four distinct sources in manual mode.
    src = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    applyStimulus(1'b0, '0, 2'b00);
    rst = 1'b0;
    #3 rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_cur_sel", 32'(cur_sel), 32'h0);
    checkOutput("reset_ack", 32'(sel_ack), 32'h0);
    checkOutput("reset_err", 32'(sel_err), 32'h0);
    checkOutput("reset_blank", 32'(blank), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("run_dout", 32'(dout), 32'h1111);
    checkOutput("run_cur_sel", 32'(cur_sel), 32'h0);

    // Manual switch to source 2, with a dropped request inside the blank window.
    expectResp(1'b1, 1'b0, 4'd2);
    applyStimulus(1'b1, 4'd2, 2'b00);
    tick();
    checkOutput("sw_cur_sel", 32'(cur_sel), 32'h2);
    checkOutput("sw_blank1", 32'(blank), 32'h1);
    checkOutput("sw_dout1", 32'(dout), 32'h0);
    checkOutput("sw_busy1", 32'(busy), 32'h1);
    applyStimulus(1'b1, 4'd1, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    checkOutput("sw_blank2", 32'(blank), 32'h1);
    checkOutput("sw_dout2", 32'(dout), 32'h0);
    tick();
    checkOutput("sw_blank_end", 32'(blank), 32'h0);
    checkOutput("sw_busy_end", 32'(busy), 32'h0);
    checkOutput("sw_dout_new", 32'(dout), 32'h3333);
    checkOutput("sw_cur_sel_kept", 32'(cur_sel), 32'h2);

    // Out-of-range index is rejected.
    expectResp(1'b0, 1'b1, 4'd2);
    applyStimulus(1'b1, 4'd5, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    checkOutput("err_cur_sel", 32'(cur_sel), 32'h2);
    checkOutput("err_blank", 32'(blank), 32'h0);
    checkOutput("err_busy", 32'(busy), 32'h0);

    // Same index is acknowledged without blanking.
    expectResp(1'b1, 1'b0, 4'd2);
    applyStimulus(1'b1, 4'd2, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    checkOutput("same_blank", 32'(blank), 32'h0);
    checkOutput("same_dout", 32'(dout), 32'h3333);

    // Select source 1 and freeze it.
    expectResp(1'b1, 1'b0, 4'd1);
    applyStimulus(1'b1, 4'd1, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    tick();
    checkOutput("hold_pre_dout", 32'(dout), 32'h2222);
    applyStimulus(1'b0, '0, 2'b10);
    tick();
    checkOutput("hold_busy", 32'(busy), 32'h1);
    src[1*WIDTH +: WIDTH] = 16'hABCD;
    applyStimulus(1'b1, 4'd3, 2'b10);
    tick();
    applyStimulus(1'b0, '0, 2'b10);
    checkOutput("hold_dout1", 32'(dout), 32'h2222);
    checkOutput("hold_cur_sel", 32'(cur_sel), 32'h1);
    tick();
    checkOutput("hold_dout2", 32'(dout), 32'h2222);
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    checkOutput("unhold_dout1", 32'(dout), 32'h2222);
    checkOutput("unhold_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("unhold_dout2", 32'(dout), 32'hABCD);

    // Back to source 0, then let auto-scan rotate through every source.
    expectResp(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd0, 2'b00);
    tick();
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    tick();
    checkOutput("pre_scan_dout", 32'(dout), 32'h1111);
    applyStimulus(1'b0, '0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      stepQ.push_back(scanSeq[i]);
      startSel = cur_sel;
      n = 0;
      do begin
        tick();
        n++;
      end while (cur_sel == startSel && n < 40);
      checkOutput("scan_gap", 32'(n), 32'(scanGap[i]));
      checkOutput("scan_sel", 32'(cur_sel), 32'(scanSeq[i]));
      checkOutput("scan_blank", 32'(blank), 32'h1);
    end

    // Request lands exactly on the scan terminal cycle.
    for (int i = 0; i < BLANK_CYC + SCAN_DIV - 1; i++) tick();
    expectResp(1'b1, 1'b0, 4'd3);
    applyStimulus(1'b1, 4'd3, 2'b01);
    tick();
    applyStimulus(1'b0, '0, 2'b01);
    checkOutput("coll_cur_sel", 32'(cur_sel), 32'h3);
    checkOutput("coll_blank", 32'(blank), 32'h1);
    tick();
    checkOutput("coll_cur_sel2", 32'(cur_sel), 32'h3);
    checkOutput("coll_blank2", 32'(blank), 32'h1);

    // Asynchronous reset in the middle of the blank window.
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_blank", 32'(blank), 32'h0);
    checkOutput("arst_dout", 32'(dout), 32'h0);
    checkOutput("arst_cur_sel", 32'(cur_sel), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, '0, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_dout", 32'(dout), 32'h1111);
    tick();
    checkOutput("resp_queue_empty", 32'(respQ.size()), 32'h0);
    checkOutput("step_queue_empty", 32'(stepQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
